pmp_check_pipe: RTL and testbench
=================================

// Module: pmp_check_pipe
// PURPOSE
// Multi-entry, pipelined PMP checker: owns NR_ENTRIES pmpcfg/pmpaddr registers with lock semantics, matches
// each request against all entries (OFF/TOR/NA4/NAPOT) and returns a priority-resolved allow/deny verdict.
// Sits between the MMU/LSU physical-address output and the memory request path; two-stage valid/ready pipe.
// PARAMETERS
// PLEN        34  physical address width in bits
// PMP_LEN     32  pmpaddr register width (holds addr[PLEN-1:2]); PMP_LEN == PLEN-2 required
// NR_ENTRIES  8   number of PMP entries, 2..16
// PORTS
// clk_i          in   1                   clock
// rst_i          in   1                   synchronous reset, active high
// cfg_we_i       in   1                   write pmpcfg[cfg_idx_i]
// cfg_idx_i      in   $clog2(NR_ENTRIES)  cfg entry index
// cfg_wdata_i    in   8                   {L,2'b0,A[1:0],X,W,R}
// addr_we_i      in   1                   write pmpaddr[addr_idx_i]
// addr_idx_i     in   $clog2(NR_ENTRIES)  addr entry index
// addr_wdata_i   in   PMP_LEN             pmpaddr value
// cfg_o          out  8*NR_ENTRIES        current pmpcfg (entry i at [8i+:8])
// addr_o         out  PMP_LEN*NR_ENTRIES  current pmpaddr
// req_valid_i    in   1                   request valid
// req_ready_o    out  1                   request accepted when valid&ready
// req_addr_i     in   PLEN                physical byte address
// req_acc_i      in   2                   0=read 1=write 2=exec (3 treated as read)
// req_m_i        in   1                   1 = effective privilege is M
// rsp_valid_o    out  1                   response valid
// rsp_ready_i    in   1                   response consumed when valid&ready
// rsp_allow_o    out  1                   access permitted
// rsp_hit_o      out  1                   some entry matched
// rsp_idx_o      out  $clog2(NR_ENTRIES)  lowest matching entry (0 if no hit)
// BEHAVIOUR
// - Reset: all pmpcfg/pmpaddr = 0 (A=OFF, L=0); s1/s2 valid = 0; rsp_valid_o/allow/hit/idx = 0; req_ready_o = 1
//   the cycle after reset deasserts. Reset mid-operation drops in-flight requests; no response is produced.
// - Match (accept cycle, combinational on current regs, registered into S1 as NR_ENTRIES-bit vector + perms):
//   OFF: no match. NA4: addr[PLEN-1:2]==pmpaddr. NAPOT: k = trailing ones of pmpaddr, size=2^(k+3);
//   match if addr & ~(size-1) == (pmpaddr<<2) & ~(size-1); pmpaddr all ones -> matches whole space.
//   TOR: (prev<<2) <= addr < (pmpaddr<<2), prev = pmpaddr[i-1], entry 0 prev = 0; prev >= cur -> no match.
//   All compares in PLEN bits, zero-extended, no overflow.
// - S1->S2: priority encode lowest matching index; allow = hit ? ((req_m_i & ~L) | perm[acc]) : req_m_i,
//   perm[0]=R, [1]=W, [2]=X. L=1 enforces on M-mode too.
// - Latency: accept at cycle t -> rsp_valid_o at t+2 with no backpressure. Throughput 1/cycle.
// - Handshake: S2 holds while rsp_valid_o & ~rsp_ready_i; S1 advances when S2 empty or draining;
//   req_ready_o = ~s1_valid | s1_advance (combinational, no dependence on req_valid_i). Outputs stable while stalled.
// - Config write same cycle as request accept: request uses OLD values; next accepted request sees NEW.
//   In-flight requests are never re-evaluated.
// - Locks: cfg write to entry i ignored if cfg[i].L=1. addr write to i ignored if cfg[i].L=1, or
//   i+1<NR_ENTRIES and cfg[i+1].A==TOR and cfg[i+1].L=1. L cleared only by reset.
// - WARL: bits[6:5] stored 0; W=1 with R=0 stores W=0. cfg and addr writes to different entries same cycle both apply.
// TESTING
// 1. Reset, no writes; req addr 0x1000 acc=0 m=0 -> allow=0 hit=0 at t+2; same with m=1 -> allow=1 hit=0.
// 2. addr[0]=0x400 (0x1000), cfg[0]=0x09 (TOR,R): read 0x0FFC m=0 -> allow=1 hit=1 idx=0; write -> allow=0;
//    read 0x1000 -> hit=0 allow=0.
// 3. addr[1]=0x5FF (NAPOT 0x1000..0x1FFF), cfg[1]=0x1F (NAPOT,RWX); cfg[2]=0x1B NAPOT,RW same addr: exec at
//    0x1800 -> idx=1 allow=1; 0x2000 -> hit=0. NAPOT addr all ones -> any address hits.
// 4. cfg[3]=0x91 (L, NA4, R) addr 0x800: write 0x2000 m=1 -> allow=0; later cfg[3]/addr[3] writes ignored;
//    cfg[4]=0x88 (L,TOR) makes addr[3] write ignored.
// 5. Backpressure: 4 back-to-back requests, rsp_ready_i low 3 cycles -> req_ready_o drops after 2 accepts,
//    responses in order, outputs stable while stalled, no loss or duplication.
// 6. Config write in accept cycle -> that request sees old config; reset asserted with 2 in flight -> no rsp.

Source files
------------

// File: rtl/pmp_check_pipe_if.sv
// Request/response handshake bundle between the address source (MMU/LSU) and the PMP checker.
// The checker side uses the slave modport; the requester side uses the master modport.
interface pmp_check_pipe_if #(
  parameter int PLEN       = 34,
  parameter int NR_ENTRIES = 8
);
  localparam int IDXW = $clog2(NR_ENTRIES);

  logic            req_valid_i;
  logic            req_ready_o;
  logic [PLEN-1:0] req_addr_i;
  logic [1:0]      req_acc_i;
  logic            req_m_i;
  logic            rsp_valid_o;
  logic            rsp_ready_i;
  logic            rsp_allow_o;
  logic            rsp_hit_o;
  logic [IDXW-1:0] rsp_idx_o;

  modport slave (
    input  req_valid_i, req_addr_i, req_acc_i, req_m_i, rsp_ready_i,
    output req_ready_o, rsp_valid_o, rsp_allow_o, rsp_hit_o, rsp_idx_o
  );

  modport master (
    output req_valid_i, req_addr_i, req_acc_i, req_m_i, rsp_ready_i,
    input  req_ready_o, rsp_valid_o, rsp_allow_o, rsp_hit_o, rsp_idx_o
  );
endinterface

// File: rtl/pmp_check_pipe.sv
// Multi-entry PMP checker: owns pmpcfg/pmpaddr with lock semantics and resolves each request
// through a two-stage valid/ready pipe (S1 = per-entry match vector, S2 = priority-resolved verdict).
module pmp_check_pipe #(
  parameter int PLEN       = 34,
  parameter int PMP_LEN    = 32,
  parameter int NR_ENTRIES = 8,
  localparam int IDXW      = $clog2(NR_ENTRIES)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          cfg_we_i,
  input  logic [IDXW-1:0]               cfg_idx_i,
  input  logic [7:0]                    cfg_wdata_i,
  input  logic                          addr_we_i,
  input  logic [IDXW-1:0]               addr_idx_i,
  input  logic [PMP_LEN-1:0]            addr_wdata_i,
  output logic [8*NR_ENTRIES-1:0]       cfg_o,
  output logic [PMP_LEN*NR_ENTRIES-1:0] addr_o,
  pmp_check_pipe_if.slave               bus
);

  localparam logic [1:0] A_TOR   = 2'b01;
  localparam logic [1:0] A_NA4   = 2'b10;
  localparam logic [1:0] A_NAPOT = 2'b11;

  logic [7:0]         r_cfg  [NR_ENTRIES];
  logic [PMP_LEN-1:0] r_addr [NR_ENTRIES];

  logic [NR_ENTRIES-1:0] w_cfg_lock;
  logic [NR_ENTRIES-1:0] w_addr_lock;
  logic [NR_ENTRIES-1:0] w_match;
  logic [NR_ENTRIES-1:0] w_perm;
  logic [7:0]            w_cfg_legal;
  logic                  w_cfg_wr_ok;
  logic                  w_addr_wr_ok;

  // WARL: reserved bits read as zero, and W without R is not a legal combination.
  assign w_cfg_legal  = {cfg_wdata_i[7], 2'b00, cfg_wdata_i[4:2],
                         cfg_wdata_i[1] & cfg_wdata_i[0], cfg_wdata_i[0]};
  assign w_cfg_wr_ok  = cfg_we_i & (32'(cfg_idx_i) < NR_ENTRIES) & ~w_cfg_lock[cfg_idx_i];
  assign w_addr_wr_ok = addr_we_i & (32'(addr_idx_i) < NR_ENTRIES) & ~w_addr_lock[addr_idx_i];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NR_ENTRIES; i++) begin
        r_cfg[i]  <= '0;
        r_addr[i] <= '0;
      end
    end else begin
      if (w_cfg_wr_ok)  r_cfg[cfg_idx_i]   <= w_cfg_legal;
      if (w_addr_wr_ok) r_addr[addr_idx_i] <= addr_wdata_i;
    end
  end

  for (genvar gi = 0; gi < NR_ENTRIES; gi++) begin : g_entry
    logic [PLEN-1:0] w_base;
    logic [PLEN-1:0] w_prev;
    logic [PLEN-1:0] w_byte;
    logic [PLEN-1:0] w_mask;
    logic            w_tor;
    logic            w_na4;
    logic            w_napot;

    assign cfg_o[8*gi +: 8]            = r_cfg[gi];
    assign addr_o[PMP_LEN*gi +: PMP_LEN] = r_addr[gi];
    assign w_cfg_lock[gi]              = r_cfg[gi][7];

    // A locked TOR entry above also freezes this entry's address, since it is that entry's lower bound.
    if (gi < NR_ENTRIES - 1) begin : g_nxt
      assign w_addr_lock[gi] = r_cfg[gi][7] | ((r_cfg[gi+1][4:3] == A_TOR) & r_cfg[gi+1][7]);
    end else begin : g_last
      assign w_addr_lock[gi] = r_cfg[gi][7];
    end

    if (gi == 0) begin : g_prev0
      assign w_prev = '0;
    end else begin : g_prevn
      assign w_prev = {r_addr[gi-1], 2'b00};
    end

    // x ^ (x+1) on {pmpaddr,2'b11} sets bits 0..k+2, i.e. size-1; all-ones wraps to a full mask.
    assign w_base  = {r_addr[gi], 2'b00};
    assign w_byte  = {r_addr[gi], 2'b11};
    assign w_mask  = ~(w_byte ^ (w_byte + PLEN'(1)));
    assign w_tor   = (w_prev <= bus.req_addr_i) && (bus.req_addr_i < w_base);
    assign w_na4   = (bus.req_addr_i[PLEN-1:2] == r_addr[gi]);
    assign w_napot = ((bus.req_addr_i & w_mask) == (w_base & w_mask));

    assign w_match[gi] = ((r_cfg[gi][4:3] == A_TOR)   & w_tor) |
                         ((r_cfg[gi][4:3] == A_NA4)   & w_na4) |
                         ((r_cfg[gi][4:3] == A_NAPOT) & w_napot);

    assign w_perm[gi] = (bus.req_acc_i == 2'd1) ? r_cfg[gi][1] :
                        (bus.req_acc_i == 2'd2) ? r_cfg[gi][2] : r_cfg[gi][0];
  end

  logic                  r_s1_valid;
  logic [NR_ENTRIES-1:0] r_s1_match;
  logic [NR_ENTRIES-1:0] r_s1_perm;
  logic [NR_ENTRIES-1:0] r_s1_lock;
  logic                  r_s1_m;

  logic                  r_s2_valid;
  logic                  r_s2_allow;
  logic                  r_s2_hit;
  logic [IDXW-1:0]       r_s2_idx;

  logic                  w_s2_free;
  logic                  w_s1_adv;
  logic                  w_accept;
  logic                  w_hit;
  logic                  w_allow;
  logic                  w_sel_perm;
  logic                  w_sel_lock;
  logic [IDXW-1:0]       w_idx;

  assign w_s2_free       = ~r_s2_valid | bus.rsp_ready_i;
  assign w_s1_adv        = r_s1_valid & w_s2_free;
  assign bus.req_ready_o = ~r_s1_valid | w_s1_adv;
  assign w_accept        = bus.req_valid_i & bus.req_ready_o;

  // Scanning downwards leaves the lowest matching entry selected.
  always_comb begin
    w_hit      = |r_s1_match;
    w_idx      = '0;
    w_sel_perm = 1'b0;
    w_sel_lock = 1'b0;
    for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
      if (r_s1_match[i]) begin
        w_idx      = IDXW'(i);
        w_sel_perm = r_s1_perm[i];
        w_sel_lock = r_s1_lock[i];
      end
    end
    w_allow = w_hit ? ((r_s1_m & ~w_sel_lock) | w_sel_perm) : r_s1_m;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s1_match <= '0;
      r_s1_perm  <= '0;
      r_s1_lock  <= '0;
      r_s1_m     <= 1'b0;
    end else if (w_accept) begin
      r_s1_valid <= 1'b1;
      r_s1_match <= w_match;
      r_s1_perm  <= w_perm;
      r_s1_lock  <= w_cfg_lock;
      r_s1_m     <= bus.req_m_i;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s2_valid <= 1'b0;
      r_s2_allow <= 1'b0;
      r_s2_hit   <= 1'b0;
      r_s2_idx   <= '0;
    end else if (w_s1_adv) begin
      r_s2_valid <= 1'b1;
      r_s2_allow <= w_allow;
      r_s2_hit   <= w_hit;
      r_s2_idx   <= w_idx;
    end else if (bus.rsp_ready_i) begin
      r_s2_valid <= 1'b0;
    end
  end

  assign bus.rsp_valid_o = r_s2_valid;
  assign bus.rsp_allow_o = r_s2_allow;
  assign bus.rsp_hit_o   = r_s2_hit;
  assign bus.rsp_idx_o   = r_s2_idx;

endmodule

// File: tb/tb_pmp_check_pipe.sv
// Directed bench for pmp_check_pipe: per-feature tasks with hand-computed expected verdicts.
module tb_pmp_check_pipe;
  localparam int PLEN    = 34;
  localparam int PMP_LEN = 32;
  localparam int NR      = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            cfg_we = 1'b0;
  logic [2:0]      cfg_idx = '0;
  logic [7:0]      cfg_wdata = '0;
  logic            addr_we = 1'b0;
  logic [2:0]      addr_idx = '0;
  logic [31:0]     addr_wdata = '0;
  logic [8*NR-1:0] cfg_o;
  logic [32*NR-1:0] addr_o;

  int n_cmp = 0;
  int n_fail = 0;

  pmp_check_pipe_if #(.PLEN(PLEN), .NR_ENTRIES(NR)) bus ();

  pmp_check_pipe #(.PLEN(PLEN), .PMP_LEN(PMP_LEN), .NR_ENTRIES(NR)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .cfg_we_i     (cfg_we),
    .cfg_idx_i    (cfg_idx),
    .cfg_wdata_i  (cfg_wdata),
    .addr_we_i    (addr_we),
    .addr_idx_i   (addr_idx),
    .addr_wdata_i (addr_wdata),
    .cfg_o        (cfg_o),
    .addr_o       (addr_o),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  task automatic write_regs(input logic cwe, input logic [2:0] ci, input logic [7:0] cd,
                            input logic awe, input logic [2:0] ai, input logic [31:0] ad);
    @(posedge clk); #1;
    cfg_we = cwe; cfg_idx = ci; cfg_wdata = cd;
    addr_we = awe; addr_idx = ai; addr_wdata = ad;
    @(posedge clk); #1;
    cfg_we = 1'b0; addr_we = 1'b0;
  endtask

  // Single request; cyc is the cycle of first rsp_valid_o counting the accept cycle as 0.
  task automatic do_req(input logic [PLEN-1:0] a, input logic [1:0] acc, input logic m,
                        output logic allow, output logic hit, output logic [2:0] idx, output int cyc);
    int w;
    allow = 1'bx; hit = 1'bx; idx = 3'bxxx; cyc = -1;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b1; bus.req_addr_i = a; bus.req_acc_i = acc; bus.req_m_i = m;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready_o && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (bus.req_ready_o) begin
      @(posedge clk); #1;
      bus.req_valid_i = 1'b0;
      cyc = 1;
      while (!bus.rsp_valid_o && cyc < 20) begin
        @(posedge clk); #1;
        cyc++;
      end
      if (bus.rsp_valid_o) begin
        allow = bus.rsp_allow_o; hit = bus.rsp_hit_o; idx = bus.rsp_idx_o;
      end
    end else begin
      bus.req_valid_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic al, ht; logic [2:0] ix; int cy;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", bus.req_ready_o); end
    n_cmp++; if (bus.rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid_o); end
    n_cmp++; if ({bus.rsp_allow_o, bus.rsp_hit_o, bus.rsp_idx_o} !== 5'b0) begin n_fail++;
      $display("FAIL reset_rsp_fields: got %b want 00000", {bus.rsp_allow_o, bus.rsp_hit_o, bus.rsp_idx_o}); end
    n_cmp++; if (cfg_o !== '0) begin n_fail++; $display("FAIL reset_cfg: got %h want 0", cfg_o); end
    n_cmp++; if (addr_o !== '0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", addr_o); end
    do_req(34'h1000, 2'd0, 1'b0, al, ht, ix, cy);
    n_cmp++; if (cy !== 2) begin n_fail++; $display("FAIL t1_latency: got %0d want 2", cy); end
    n_cmp++; if ({al, ht} !== 2'b00) begin n_fail++; $display("FAIL t1_u_nohit: got allow=%b hit=%b want 0 0", al, ht); end
    do_req(34'h1000, 2'd0, 1'b1, al, ht, ix, cy);
    n_cmp++; if ({al, ht, ix} !== 5'b10000) begin n_fail++; $display("FAIL t1_m_nohit: got %b%b%b want 1 0 000", al, ht, ix); end
  endtask

  task automatic test_tor();
    logic al, ht; logic [2:0] ix; int cy;
    write_regs(1'b0, 3'd0, 8'h00, 1'b1, 3'd0, 32'h400);
    write_regs(1'b1, 3'd0, 8'h09, 1'b0, 3'd0, 32'h0);
    n_cmp++; if (cfg_o[7:0] !== 8'h09) begin n_fail++; $display("FAIL tor_cfg0: got %h want 09", cfg_o[7:0]); end
    do_req(34'h0FFC, 2'd0, 1'b0, al, ht, ix, cy);
    n_cmp++; if ({al, ht, ix} !== 5'b11000) begin n_fail++; $display("FAIL tor_read_in: got %b%b%b want 1 1 000", al, ht, ix); end
    do_req(34'h0FFC, 2'd1, 1'b0, al, ht, ix, cy);
    n_cmp++; if ({al, ht, ix} !== 5'b01000) begin n_fail++; $display("FAIL tor_write_in: got %b%b%b want 0 1 000", al, ht, ix); end
    do_req(34'h1000, 2'd0, 1'b0, al, ht, ix, cy);
    n_cmp++; if ({al, ht} !== 2'b00) begin n_fail++; $display("FAIL tor_top_excl: got allow=%b hit=%b want 0 0", al, ht); end
  endtask

  task automatic test_napot();
    logic al, ht; logic [2:0] ix; int cy;
    // cfg and addr writes to different entries in the same cycle
    write_regs(1'b1, 3'd1, 8'h1F, 1'b1, 3'd2, 32'h5FF);
    n_cmp++; if (cfg_o[15:8] !== 8'h1F) begin n_fail++; $display("FAIL dual_wr_cfg1: got %h want 1f", cfg_o[15:8]); end
    n_cmp++; if (addr_o[95:64] !== 32'h5FF) begin n_fail++; $display("FAIL dual_wr_addr2: got %h want 5ff", addr_o[95:64]); end
    write_regs(1'b0, 3'd0, 8'h00, 1'b1, 3'd1, 32'h5FF);
    write_regs(1'b1, 3'd2, 8'h1B, 1'b0, 3'd0, 32'h0);
    do_req(34'h1800, 2'd2, 1'b0, al, ht, ix, cy);
    n_cmp++; if ({al, ht, ix} !== 5'b11001) begin n_fail++; $display("FAIL napot_exec: got %b%b%b want 1 1 001", al, ht, ix); end
    do_req(34'h2000, 2'd2, 1'b0, al, ht, ix, cy);
    n_cmp++; if ({al, ht} !== 2'b00) begin n_fail++; $display("FAIL napot_above: got allow=%b hit=%b want 0 0", al, ht); end
    write_regs(1'b1, 3'd5, 8'h18, 1'b1, 3'd5, 32'hFFFF_FFFF);
    do_req(34'h3_FFFF_FFF0, 2'd0, 1'b0, al, ht, ix, cy);
    n_cmp++; if ({al, ht, ix} !== 5'b01101) begin n_fail++; $display("FAIL napot_all_ones: got %b%b%b want 0 1 101", al, ht, ix); end
    write_regs(1'b1, 3'd6, 8'h7E, 1'b0, 3'd0, 32'h0);
    n_cmp++; if (cfg_o[55:48] !== 8'h1C) begin n_fail++; $display("FAIL warl_cfg6: got %h want 1c", cfg_o[55:48]); end
    write_regs(1'b1, 3'd6, 8'h00, 1'b0, 3'd0, 32'h0);
    write_regs(1'b1, 3'd5, 8'h00, 1'b0, 3'd0, 32'h0);
  endtask

  task automatic test_lock();
    logic al, ht; logic [2:0] ix; int cy;
    write_regs(1'b0, 3'd0, 8'h00, 1'b1, 3'd3, 32'h800);
    write_regs(1'b1, 3'd3, 8'h91, 1'b0, 3'd0, 32'h0);
    do_req(34'h2000, 2'd1, 1'b1, al, ht, ix, cy);
    n_cmp++; if ({al, ht, ix} !== 5'b01011) begin n_fail++; $display("FAIL lock_m_write: got %b%b%b want 0 1 011", al, ht, ix); end
    do_req(34'h2002, 2'd0, 1'b1, al, ht, ix, cy);
    n_cmp++; if ({al, ht, ix} !== 5'b11011) begin n_fail++; $display("FAIL lock_m_read: got %b%b%b want 1 1 011", al, ht, ix); end
    write_regs(1'b1, 3'd3, 8'h00, 1'b1, 3'd3, 32'h900);
    n_cmp++; if (cfg_o[31:24] !== 8'h91) begin n_fail++; $display("FAIL lock_cfg3_kept: got %h want 91", cfg_o[31:24]); end
    n_cmp++; if (addr_o[127:96] !== 32'h800) begin n_fail++; $display("FAIL lock_addr3_kept: got %h want 800", addr_o[127:96]); end
    write_regs(1'b1, 3'd4, 8'h88, 1'b1, 3'd6, 32'h123);
    n_cmp++; if (cfg_o[39:32] !== 8'h88) begin n_fail++; $display("FAIL lock_cfg4: got %h want 88", cfg_o[39:32]); end
    n_cmp++; if (addr_o[223:192] !== 32'h123) begin n_fail++; $display("FAIL addr6_open: got %h want 123", addr_o[223:192]); end
    write_regs(1'b1, 3'd7, 8'h88, 1'b0, 3'd0, 32'h0);
    write_regs(1'b0, 3'd0, 8'h00, 1'b1, 3'd6, 32'h456);
    n_cmp++; if (addr_o[223:192] !== 32'h123) begin n_fail++; $display("FAIL tor_lock_addr6: got %h want 123", addr_o[223:192]); end
  endtask

  task automatic test_back_to_back();
    logic [33:0] va [4];
    logic [1:0]  vacc [4];
    logic [4:0]  exp_rsp [4];
    logic [4:0]  got_q [$];
    logic [4:0]  prev_out;
    logic [4:0]  got;
    logic        prev_stall;
    logic        do_acc;
    int acc_cnt, cyc, first_drop, n_stable;
    va = '{34'h0800, 34'h1800, 34'h2000, 34'h3000};
    vacc = '{2'd0, 2'd1, 2'd2, 2'd0};
    exp_rsp = '{5'b11000, 5'b11001, 5'b01011, 5'b00000};
    acc_cnt = 0; cyc = 0; first_drop = -1; n_stable = 0;
    prev_stall = 1'b0; prev_out = '0;
    @(posedge clk); #1;
    while ((acc_cnt < 4 || got_q.size() < 4) && cyc < 40) begin
      bus.rsp_ready_i = (cyc >= 3);
      bus.req_valid_i = (acc_cnt < 4);
      if (acc_cnt < 4) begin
        bus.req_addr_i = va[acc_cnt]; bus.req_acc_i = vacc[acc_cnt]; bus.req_m_i = 1'b0;
      end
      @(negedge clk);
      if (prev_stall) begin
        n_stable++;
        n_cmp++; if ({bus.rsp_valid_o, bus.rsp_allow_o, bus.rsp_hit_o, bus.rsp_idx_o} !== {1'b1, prev_out}) begin n_fail++;
          $display("FAIL bp_stable: got %b want %b", {bus.rsp_valid_o, bus.rsp_allow_o, bus.rsp_hit_o, bus.rsp_idx_o}, {1'b1, prev_out}); end
      end
      prev_stall = bus.rsp_valid_o && !bus.rsp_ready_i;
      prev_out = {bus.rsp_allow_o, bus.rsp_hit_o, bus.rsp_idx_o};
      if (bus.rsp_valid_o && bus.rsp_ready_i) got_q.push_back(prev_out);
      if (bus.req_valid_i && !bus.req_ready_o && first_drop < 0) first_drop = acc_cnt;
      do_acc = bus.req_valid_i && bus.req_ready_o;
      @(posedge clk); #1;
      if (do_acc) acc_cnt++;
      cyc++;
    end
    bus.req_valid_i = 1'b0; bus.rsp_ready_i = 1'b1;
    n_cmp++; if (first_drop !== 2) begin n_fail++; $display("FAIL bp_ready_drop: got after %0d accepts want 2", first_drop); end
    n_cmp++; if (n_stable !== 1) begin n_fail++; $display("FAIL bp_stall_cycles: got %0d want 1", n_stable); end
    n_cmp++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      got = (i < got_q.size()) ? got_q[i] : 5'bxxxxx;
      n_cmp++; if (got !== exp_rsp[i]) begin n_fail++; $display("FAIL bp_rsp%0d: got %b want %b", i, got, exp_rsp[i]); end
    end
    @(negedge clk);
    n_cmp++; if (bus.rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL bp_no_dup: got rsp_valid %b want 0", bus.rsp_valid_o); end
  endtask

  task automatic test_cfg_same_cycle();
    logic al, ht; logic [2:0] ix; int cy;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b1; bus.req_addr_i = 34'h3000; bus.req_acc_i = 2'd0; bus.req_m_i = 1'b0;
    cfg_we = 1'b1; cfg_idx = 3'd5; cfg_wdata = 8'h19;
    @(negedge clk);
    n_cmp++; if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL samecyc_ready: got %b want 1", bus.req_ready_o); end
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0; cfg_we = 1'b0;
    cy = 1;
    while (!bus.rsp_valid_o && cy < 20) begin
      @(posedge clk); #1;
      cy++;
    end
    n_cmp++; if ({bus.rsp_valid_o, bus.rsp_allow_o, bus.rsp_hit_o} !== 3'b100) begin n_fail++;
      $display("FAIL samecyc_old_cfg: got valid/allow/hit %b want 100", {bus.rsp_valid_o, bus.rsp_allow_o, bus.rsp_hit_o}); end
    n_cmp++; if (cfg_o[47:40] !== 8'h19) begin n_fail++; $display("FAIL samecyc_cfg5: got %h want 19", cfg_o[47:40]); end
    do_req(34'h3000, 2'd0, 1'b0, al, ht, ix, cy);
    n_cmp++; if ({al, ht, ix} !== 5'b11101) begin n_fail++; $display("FAIL samecyc_new_cfg: got %b%b%b want 1 1 101", al, ht, ix); end
  endtask

  task automatic test_reset_inflight();
    int n_rsp;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 1'b1; bus.req_addr_i = 34'h0800; bus.req_acc_i = 2'd0; bus.req_m_i = 1'b0;
    @(posedge clk); #1;
    bus.req_addr_i = 34'h1800;
    @(posedge clk); #1;
    n_cmp++; if (bus.rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL inflight_rsp: got %b want 1", bus.rsp_valid_o); end
    bus.req_valid_i = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rsp_ready_i = 1'b1;
    n_rsp = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.rsp_valid_o) n_rsp++;
    end
    n_cmp++; if (n_rsp !== 0) begin n_fail++; $display("FAIL rst_drop_rsp: got %0d responses want 0", n_rsp); end
    n_cmp++; if (bus.req_ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b want 1", bus.req_ready_o); end
    n_cmp++; if (cfg_o !== '0) begin n_fail++; $display("FAIL rst_cfg_clear: got %h want 0", cfg_o); end
    write_regs(1'b1, 3'd3, 8'h01, 1'b0, 3'd0, 32'h0);
    n_cmp++; if (cfg_o[31:24] !== 8'h01) begin n_fail++; $display("FAIL rst_unlock_cfg3: got %h want 01", cfg_o[31:24]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_acc_i   = 2'd0;
    bus.req_m_i     = 1'b0;
    bus.rsp_ready_i = 1'b1;
    test_reset();
    test_tor();
    test_napot();
    test_lock();
    test_back_to_back();
    test_cfg_same_cycle();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
